// File: rtl/dm_store_ctrl_pkg.sv
// Shared encodings for the data-memory store path: store opcodes, FSM states,
// queue entry layout and the lane-steering helpers.
package dm_store_ctrl_pkg;

    localparam logic [1:0] SOP_SB  = 2'd0;
    localparam logic [1:0] SOP_SH  = 2'd1;
    localparam logic [1:0] SOP_SW  = 2'd2;
    localparam logic [1:0] SOP_NOP = 2'd3;

    // Load-side extension opcodes, shared with the load unit.
    localparam logic [2:0] LOP_LB  = 3'd0;
    localparam logic [2:0] LOP_LH  = 3'd1;
    localparam logic [2:0] LOP_LW  = 3'd2;
    localparam logic [2:0] LOP_LBU = 3'd4;
    localparam logic [2:0] LOP_LHU = 3'd5;

    typedef enum logic [0:0] {
        StIdle,
        StWrite
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_entry_t;

    localparam int unsigned ENTRY_W = $bits(store_entry_t);

    function automatic logic [3:0] lane_be(input logic [1:0] op, input logic [1:0] a);
        case (op)
            SOP_SB:  return 4'b0001 << a;
            SOP_SH:  return a[1] ? 4'b1100 : 4'b0011;
            SOP_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] op, input logic [31:0] d);
        case (op)
            SOP_SB:  return {4{d[7:0]}};
            SOP_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/dm_store_ctrl_fifo.sv
// store_fifo: circular store queue; pointers wrap naturally since DEPTH is a
// power of two. Payload RAM is not reset, only pointers and count are.
module store_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 68,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/dm_store_ctrl.sv
// Store controller: lane-steers and alignment-checks pipeline stores, queues
// them, and drains them to data memory one write per acknowledged cycle.
module dm_store_ctrl
    import dm_store_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_op,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        ades,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic          full, empty;
    logic          misaligned, accept, push, pop;
    store_entry_t  new_entry, head;
    state_t        state;

    always_comb begin
        misaligned = ((req_op == SOP_SH) && req_addr[0]) ||
                     ((req_op == SOP_SW) && (req_addr[1:0] != 2'b00));
        accept     = req_valid && req_ready;
        push       = accept && (req_op != SOP_NOP) && !misaligned;
        new_entry.addr  = {req_addr[31:2], 2'b00};
        new_entry.be    = lane_be(req_op, req_addr[1:0]);
        new_entry.wdata = lane_data(req_op, req_data);
    end

    // Readiness comes from the registered count only, so a same-cycle pop never raises it.
    assign req_ready = !full;
    assign pop       = !empty && ((state == StIdle) || mem_ack);
    assign busy      = (count != '0) || mem_we;

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (new_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ades      <= 1'b0;
        end else begin
            ades <= accept && misaligned;
            case (state)
                StIdle: begin
                    if (!empty) begin
                        state     <= StWrite;
                        mem_we    <= 1'b1;
                        mem_addr  <= head.addr;
                        mem_be    <= head.be;
                        mem_wdata <= head.wdata;
                    end
                end
                StWrite: begin
                    if (mem_ack) begin
                        if (!empty) begin
                            mem_addr  <= head.addr;
                            mem_be    <= head.be;
                            mem_wdata <= head.wdata;
                        end else begin
                            state  <= StIdle;
                            mem_we <= 1'b0;
                            mem_be <= '0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
